alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked, multi-cycle ALU; next generation of the 16-bit combinational ALU for the demo pipeline's execute stage.
- Keeps the single-cycle shift, add and logic ops, with the result now registered.
- Adds iterative multiply (low and high half) and divide/remainder, signed or unsigned.
- Uses valid/ready handshakes on both sides so the pipeline can stall on long ops.

Parameters:
N  16  operand/result width (>=4, power of 2)
O  4   opcode width (fixed encoding below)

Ports:
clk        in   1   clock, all state on rising edge
rst_n      in   1   synchronous active-low reset
in_valid   in   1   operation request
in_ready   out  1   block can accept a request
A          in   N   operand A
B          in   N   operand B; shift amount = B[log2(N)-1:0]
Cin        in   1   adder carry-in (ADD only)
Op         in   O   opcode
invA       in   1   invert A before any op
invB       in   1   invert B before any op
sign       in   1   1 = two's-complement semantics
out_valid  out  1   result valid
out_ready  in   1   consumer accepts result
Out        out  N   result
Zero       out  1   Out == 0
Ofl        out  1   overflow / exception
Carry      out  1   adder carry-out (ADD only, else 0)
Neg        out  1   Out[N-1]

Behaviour:
- Opcodes:
  - 0000 ROL, 0001 SLL, 0010 ROR, 0011 SRL, 0100 SRA.
  - 1000 ADD, 1001 AND, 1010 OR, 1011 XOR.
  - 1100 MUL (low N bits), 1101 MULH (high N bits), 1110 DIV, 1111 REM.
  - 0101-0111 are reserved: Out=0, single cycle.
- Operand capture:
  - OpA/OpB = invA/invB-conditioned A/B, captured into internal registers on accept (in_valid & in_ready).
  - After accept, inputs are don't-care.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1.
    - Accept of a single-cycle op -> DONE. Result is registered, so out_valid=1 the cycle after accept (latency 1).
    - Accept of MUL/MULH/DIV/REM -> CALC with iteration counter=0.
  - CALC: in_ready=0, out_valid=0. One iteration per cycle.
    - Counter reaching N-1 -> DONE.
    - Latency from accept to out_valid is N+1 cycles (17 at N=16).
  - DONE: out_valid=1.
    - Out and flags are held stable until out_ready=1.
    - in_ready = out_ready, so back-to-back accept is allowed in the same cycle the result retires.
    - Result retiring with no new accept -> IDLE.
    - Result retiring with an accept -> DONE or CALC as for IDLE.
- MUL/MULH:
  - Shift-add into a 2N-bit accumulator.
  - If sign=1: operate on magnitudes, then negate the 2N product when operand signs differ.
  - MUL: Ofl=1 if the high half is not the sign extension of the low half (signed), or is nonzero (unsigned).
  - MULH: Ofl=0.
- DIV/REM:
  - Restoring division on magnitudes. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - B==0: quotient=all ones, remainder=OpA, Ofl=1. Still takes N+1 cycles.
  - Signed MIN/-1: quotient=MIN, remainder=0, Ofl=1.
- ADD: Ofl = signed overflow when sign=1, else Cout.
- Ofl for shifts and logic ops is 0.
- Zero=~|Out and Neg=Out[N-1] for all ops.
- Reset:
  - Values: state=IDLE, out_valid=0, Out=0, Zero=1, Ofl=0, Carry=0, Neg=0, in_ready=1 after the reset cycle.
  - Reset mid-CALC aborts the operation with no result emitted.
- in_valid while in_ready=0 is ignored. The requester must hold the request.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: divider datapath is built; DIV/REM behave as above.
- Undefined:
  - No divider logic is built.
  - DIV/REM complete in 1 cycle with Out=0, Ofl=1, Zero=1.
  - MUL/MULH are unchanged.

Test Plan:
1. ADD, sign=1, A=7FFF, B=0001, Cin=0 -> out_valid next cycle; Out=8000, Ofl=1, Neg=1, Carry=0, Zero=0.
2. MUL, unsigned, A=0012, B=0034 -> out_valid 17 cycles after accept; Out=03A8, Ofl=0. Then MULH, signed, A=FFFF, B=0002 -> Out=FFFF.
3. DIV/REM, unsigned, A=0064, B=0007 -> 000E / 0002. Signed, A=FF9C, B=0007 -> FFF2 / FFFE, Ofl=0.
4. DIV, A=1234, B=0000 -> Out=FFFF, Ofl=1. REM, same operands -> Out=1234, Ofl=1. Signed DIV, A=8000, B=FFFF -> Out=8000, Ofl=1.
5. Backpressure: XOR A=00FF, B=0F0F, out_ready=0 for 5 cycles -> Out=0FF0 held, out_valid=1, in_ready=0. out_ready=1 with a new ADD presented -> retire and accept in the same cycle.
6. rst_n=0 on cycle 5 of a MUL -> next cycle out_valid=0, Out=0, Zero=1, in_ready=1. No stale result appears afterwards.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: registered shift/add/logic ops, iterative MUL/MULH and DIV/REM.
// Macro ALU_DIV_EN builds the restoring divider; without it DIV/REM finish in one cycle with Ofl set.
module alu_seq #(
  parameter int unsigned N = 16,
  parameter int unsigned O = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [O-1:0] Op,
  input  logic         invA,
  input  logic         invB,
  input  logic         sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         Zero,
  output logic         Ofl,
  output logic         Carry,
  output logic         Neg
);

  localparam int unsigned SW  = $clog2(N);
  localparam int unsigned SW1 = SW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_d;
  logic            accept, multi, last;
  logic [SW-1:0]   cnt;

  logic [N-1:0]    opa, opb, ma, mb, rol, ror;
  logic            a_neg, b_neg, add_ovf;
  logic [SW-1:0]   amt;
  logic [SW:0]     ramt;
  logic [N:0]      add_w;
  logic [N-1:0]    s_out;
  logic            s_ofl, s_carry;

  logic [N-1:0]    hi, lo, m, hi_n, lo_n, c_out;
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  prod, prod_s;
  logic            is_hi, sgn_q, neg_q, c_ofl;
`ifdef ALU_DIV_EN
  logic            is_div, neg_a, b_zero, min_m1, div_ge;
  logic [N:0]      div_sh;
  logic [N-1:0]    div_sub, quo, rem;
`endif

  // Operand conditioning and sign/magnitude split for the iterative units
  assign opa   = invA ? ~A : A;
  assign opb   = invB ? ~B : B;
  assign a_neg = sign & opa[N-1];
  assign b_neg = sign & opb[N-1];
  assign ma    = a_neg ? -opa : opa;
  assign mb    = b_neg ? -opb : opb;

  assign amt     = opb[SW-1:0];
  assign ramt    = SW1'(N) - {1'b0, amt};
  assign rol     = (opa << amt) | (opa >> ramt);
  assign ror     = (opa >> amt) | (opa << ramt);
  assign add_w   = {1'b0, opa} + {1'b0, opb} + {{N{1'b0}}, Cin};
  assign add_ovf = (opa[N-1] == opb[N-1]) && (add_w[N-1] != opa[N-1]);

`ifdef ALU_DIV_EN
  assign multi = (Op[3:2] == 2'b11);
`else
  assign multi = (Op[3:1] == 3'b110);
`endif
  assign last = (cnt == SW'(N - 1));

  // Single-cycle result
  always_comb begin
    s_out   = '0;
    s_ofl   = 1'b0;
    s_carry = 1'b0;
    case (Op[3:0])
      4'b0000: s_out = rol;
      4'b0001: s_out = opa << amt;
      4'b0010: s_out = ror;
      4'b0011: s_out = opa >> amt;
      4'b0100: s_out = $unsigned($signed(opa) >>> amt);
      4'b1000: begin
        s_out   = add_w[N-1:0];
        s_carry = add_w[N];
        s_ofl   = sign ? add_ovf : add_w[N];
      end
      4'b1001: s_out = opa & opb;
      4'b1010: s_out = opa | opb;
      4'b1011: s_out = opa ^ opb;
`ifndef ALU_DIV_EN
      4'b1110, 4'b1111: s_ofl = 1'b1;
`endif
      default: ;
    endcase
  end

  // One shift-add (or restoring-divide) step; hi/lo share the accumulator
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    hi_n    = mul_sum[N:1];
    lo_n    = {mul_sum[0], lo[N-1:1]};
`ifdef ALU_DIV_EN
    div_sh  = {hi, lo[N-1]};
    div_ge  = (m != '0) && (div_sh >= {1'b0, m});
    div_sub = div_sh[N-1:0] - m;
    if (is_div) begin
      hi_n = div_ge ? div_sub : div_sh[N-1:0];
      lo_n = {lo[N-2:0], div_ge};
    end
`endif
  end

  // Sign fix-up and result select on the final iteration
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    c_out  = is_hi ? prod_s[2*N-1:N] : prod_s[N-1:0];
    if (is_hi)      c_ofl = 1'b0;
    else if (sgn_q) c_ofl = (prod_s[2*N-1:N] != {N{prod_s[N-1]}});
    else            c_ofl = |prod_s[2*N-1:N];
`ifdef ALU_DIV_EN
    quo = neg_q ? -lo_n : lo_n;
    rem = neg_a ? -hi_n : hi_n;
    if (is_div) begin
      c_out = is_hi ? rem : (b_zero ? '1 : quo);
      c_ofl = b_zero | min_m1;
    end
`endif
  end

  // Next state and request acceptance
  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    case (state)
      IDLE: if (accept) state_d = multi ? CALC : DONE;
      CALC: if (last) state_d = DONE;
      DONE: begin
        if (accept)         state_d = multi ? CALC : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Out       <= '0;
      Zero      <= 1'b1;
      Ofl       <= 1'b0;
      Carry     <= 1'b0;
      Neg       <= 1'b0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      m         <= '0;
      is_hi     <= 1'b0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
`ifdef ALU_DIV_EN
      is_div    <= 1'b0;
      neg_a     <= 1'b0;
      b_zero    <= 1'b0;
      min_m1    <= 1'b0;
`endif
    end else begin
      out_valid <= (state_d == DONE);
      if (accept && !multi) begin
        Out   <= s_out;
        Zero  <= ~|s_out;
        Neg   <= s_out[N-1];
        Ofl   <= s_ofl;
        Carry <= s_carry;
      end
      if (accept && multi) begin
        cnt    <= '0;
        hi     <= '0;
        is_hi  <= Op[0];
        sgn_q  <= sign;
        neg_q  <= a_neg ^ b_neg;
`ifdef ALU_DIV_EN
        is_div <= Op[1];
        neg_a  <= a_neg;
        b_zero <= (opb == '0);
        min_m1 <= sign && (opa == {1'b1, {(N-1){1'b0}}}) && (&opb);
        m      <= Op[1] ? mb : ma;
        lo     <= Op[1] ? ma : mb;
`else
        m      <= ma;
        lo     <= mb;
`endif
      end else if (state == CALC) begin
        cnt <= cnt + SW'(1);
        hi  <= hi_n;
        lo  <= lo_n;
        if (last) begin
          Out   <= c_out;
          Zero  <= ~|c_out;
          Neg   <= c_out[N-1];
          Ofl   <= c_ofl;
          Carry <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, Cin, invA, invB, sign;
  logic        out_valid, out_ready, Zero, Ofl, Carry, Neg;
  logic [15:0] A, B, Out;
  logic [3:0]  Op;
  int          tests = 0;
  int          fails = 0;

  alu_seq #(.N(16), .O(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
    .Zero(Zero), .Ofl(Ofl), .Carry(Carry), .Neg(Neg)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model on already-conditioned operands; lat counts cycles from accept to out_valid
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sg, output logic [15:0] o,
                                output logic ofl, output logic cy, output int lat);
    longint      sa, sb, p;
    logic [63:0] pv;
    int          sh, s;
    o = '0; ofl = 1'b0; cy = 1'b0; lat = 1;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    sh = int'(b[3:0]);
    case (op)
      4'b0000: begin o = a; repeat (sh) o = {o[14:0], o[15]}; end
      4'b0001: o = a << sh;
      4'b0010: begin o = a; repeat (sh) o = {o[0], o[15:1]}; end
      4'b0011: o = a >> sh;
      4'b0100: begin o = a; repeat (sh) o = {o[15], o[15:1]}; end
      4'b1000: begin
        s  = int'(a) + int'(b) + int'(cin);
        o  = 16'(s);
        cy = (s > 65535);
        if (sg) begin
          p   = sa + sb + longint'(cin);
          ofl = (p > 32767) || (p < -32768);
        end else ofl = cy;
      end
      4'b1001: o = a & b;
      4'b1010: o = a | b;
      4'b1011: o = a ^ b;
      4'b1100, 4'b1101: begin
        p   = sa * sb;
        pv  = 64'(p);
        lat = 17;
        if (op[0]) o = pv[31:16];
        else begin
          o   = pv[15:0];
          ofl = sg ? ((p > 32767) || (p < -32768)) : (p > 65535);
        end
      end
      4'b1110, 4'b1111: begin
`ifdef ALU_DIV_EN
        logic [15:0] q, r;
        lat = 17;
        if (b == 16'h0000) begin
          q = 16'hFFFF; r = a; ofl = 1'b1;
        end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
          q = 16'h8000; r = 16'h0000; ofl = 1'b1;
        end else begin
          q = 16'(sa / sb); r = 16'(sa % sb);
        end
        o = op[0] ? r : q;
`else
        o = 16'h0000; ofl = 1'b1; lat = 1;
`endif
      end
      default: ;
    endcase
  endfunction

  // Issue one op, optionally hold out_ready low for some cycles after the result, check, retire
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic ia, input logic ib,
                        input logic sg, input int stall, output logic [15:0] got);
    logic [15:0] eo;
    logic        eofl, ecy;
    int          elat, lat;
    bit          seen;
    model(op, ia ? ~a : a, ib ? ~b : b, cin, sg, eo, eofl, ecy, elat);
    @(negedge clk);
    Op = op; A = a; B = b; Cin = cin; invA = ia; invB = ib; sign = sg;
    in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (elat > 1) check({tag, " in_ready_busy"}, 32'(in_ready), 32'(0));
        in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); Op = 4'($urandom);
      end
      if (out_valid) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    repeat (stall) @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'(1));
    check({tag, " Out"}, 32'(Out), 32'(eo));
    check({tag, " flags_ZOCN"}, 32'({Zero, Ofl, Carry, Neg}),
          32'({(eo == 16'h0000), eofl, ecy, eo[15]}));
    got = Out;
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [15:0] o;
    bit          stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Op = '0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'(0));
    check("reset Out", 32'(Out), 32'(0));
    check("reset flags_ZOCN", 32'({Zero, Ofl, Carry, Neg}), 32'(4'b1000));
    check("reset in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;

    run_op("tp1_add", 4'b1000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, o);
    check("tp1_add const", 32'(o), 32'(16'h8000));
    run_op("tp2_mul", 4'b1100, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp2_mul const", 32'(o), 32'(16'h03A8));
    run_op("tp2_mulh", 4'b1101, 16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 0, o);
    check("tp2_mulh const", 32'(o), 32'(16'hFFFF));
    run_op("tp2_rol", 4'b0000, 16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp2_rol const", 32'(o), 32'(16'h0003));

`ifdef ALU_DIV_EN
    run_op("tp3_divu", 4'b1110, 16'h0064, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp3_divu const", 32'(o), 32'(16'h000E));
    run_op("tp3_remu", 4'b1111, 16'h0064, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp3_remu const", 32'(o), 32'(16'h0002));
    run_op("tp3_divs", 4'b1110, 16'hFF9C, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 0, o);
    check("tp3_divs const", 32'(o), 32'(16'hFFF2));
    run_op("tp3_rems", 4'b1111, 16'hFF9C, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 1, o);
    check("tp3_rems const", 32'(o), 32'(16'hFFFE));
    run_op("tp4_div0", 4'b1110, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp4_div0 const", 32'(o), 32'(16'hFFFF));
    run_op("tp4_rem0", 4'b1111, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp4_rem0 const", 32'(o), 32'(16'h1234));
    run_op("tp4_minm1", 4'b1110, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, o);
    check("tp4_minm1 const", 32'(o), 32'(16'h8000));
`else
    run_op("tp3_div_off", 4'b1110, 16'h0064, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 0, o);
    check("tp3_div_off const", 32'(o), 32'(16'h0000));
    run_op("tp4_rem_off", 4'b1111, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, o);
    check("tp4_rem_off const", 32'(o), 32'(16'h0000));
`endif
    run_op("reserved", 4'b0110, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 0, o);

    // Backpressure: result held, then retire and accept in the same cycle
    @(negedge clk);
    Op = 4'b1011; A = 16'h00FF; B = 16'h0F0F; Cin = 1'b0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tp5_hold%0d out_valid", i), 32'(out_valid), 32'(1));
      check($sformatf("tp5_hold%0d Out", i), 32'(Out), 32'(16'h0FF0));
      check($sformatf("tp5_hold%0d in_ready", i), 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    Op = 4'b1000; A = 16'h1234; B = 16'h1111; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("tp5 in_ready_on_retire", 32'(in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("tp5 b2b out_valid", 32'(out_valid), 32'(1));
    check("tp5 b2b Out", 32'(Out), 32'(16'h2346));
    @(posedge clk);

    // Reset on cycle 5 of a MUL aborts it
    @(negedge clk);
    Op = 4'b1100; A = 16'h1234; B = 16'h5678; sign = 1'b0; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("tp6 out_valid", 32'(out_valid), 32'(0));
    check("tp6 Out", 32'(Out), 32'(0));
    check("tp6 Zero", 32'(Zero), 32'(1));
    check("tp6 in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("tp6 no_stale_result", 32'(stale), 32'(0));

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      int          sel;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 16'h0000;
      if (sel == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
      run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), ra, rb, 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2), o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
